// File: rtl/sram_mem_controller.sv
// MEM-stage data access sequencer for a 16-bit asynchronous SRAM: each 32-bit access is two timed halfword phases.
// Optional MEM_BOUNDS_CHECK_EN: out-of-range requests skip the SRAM and pulse addr_err.
module sram_mem_controller #(
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = 1024,
  parameter int DEPTH_WORDS = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] res_data,
  output logic        ready,
  output logic        addr_err,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST_PHASE = 4'(WAIT_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  phase, phase_next;
  logic [16:0] word_q, word_next;
  logic [31:0] wdata_q, wdata_next;
  logic        store_q, store_next;

  logic        req;
  logic        last_phase;
  logic [31:0] off;
  logic        oob;
  logic        range_bad;
  logic        unused_bits;

  logic [17:0] sram_addr_next;
  logic [15:0] dq_out_next;
  logic        oe_next;
  logic        we_n_next;

  assign req        = mem_r_en | mem_w_en;
  assign last_phase = (phase == LAST_PHASE);
  assign off        = alu_res - 32'(BASE_ADDR);
  assign oob        = (alu_res < 32'(BASE_ADDR)) || ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));
  assign ready      = ~req | (state == DONE);

  // Byte-lane bits are ignored; oob is only consumed when the bounds check is built in.
  assign unused_bits = ^{off[1:0], oob};

`ifdef MEM_BOUNDS_CHECK_EN
  assign range_bad = oob;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= (state == IDLE) && req && range_bad;
    end
  end
`else
  assign range_bad = 1'b0;
  assign addr_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= 4'd0;
      word_q  <= 17'd0;
      wdata_q <= 32'd0;
      store_q <= 1'b0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      word_q  <= word_next;
      wdata_q <= wdata_next;
      store_q <= store_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    word_next  = word_q;
    wdata_next = wdata_q;
    store_next = store_q;
    unique case (state)
      IDLE: begin
        if (req) begin
          word_next  = off[18:2];
          wdata_next = Val_Rm;
          store_next = mem_w_en;
          phase_next = 4'd0;
          state_next = range_bad ? DONE : LO;
        end
      end
      LO: begin
        if (last_phase) begin
          state_next = HI;
          phase_next = 4'd0;
        end else begin
          phase_next = phase + 4'd1;
        end
      end
      HI: begin
        if (last_phase) begin
          state_next = DONE;
          phase_next = 4'd0;
        end else begin
          phase_next = phase + 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // SRAM pins are registered from the next-state view so the write strobe never glitches.
  always_comb begin
    oe_next        = store_next && ((state_next == LO) || (state_next == HI));
    we_n_next      = ~(oe_next && (phase_next != LAST_PHASE));
    sram_addr_next = {word_next, state_next == HI};
    dq_out_next    = (state_next == HI) ? wdata_next[31:16] : wdata_next[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      sram_addr   <= sram_addr_next;
      sram_dq_out <= dq_out_next;
      sram_dq_oe  <= oe_next;
      sram_we_n   <= we_n_next;
    end
  end

  // Load halves are captured at the end of each phase, once the SRAM read has had the full wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= 32'd0;
    end else if ((state == IDLE) && req && range_bad && !mem_w_en) begin
      res_data <= 32'd0;
    end else if ((state == LO) && last_phase && !store_q) begin
      res_data[15:0] <= sram_dq_in;
    end else if ((state == HI) && last_phase && !store_q) begin
      res_data[31:16] <= sram_dq_in;
    end
  end

endmodule
